// File: rtl/pipelined_controller_hz.sv
// RV32I control unit: decodes in D and carries control bits through the E/M/W pipeline registers.
// Define CONTROLLER_UNSIGNED_BRANCH_EN to accept BLTU/BGEU/SLTU/SLTIU; otherwise they decode as illegal.
module pipelined_controller_hz #(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 InstrValidD,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 NegativeE,
    input  logic                 OverflowE,
    input  logic                 CarryE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic                 PCSrcE,
    output logic                 PCTargetSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcAE,
    output logic                 ALUSrcBE,
    output logic [1:0]           ResultSrcE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic [CNT_W-1:0]     RetireCount
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9;

    function automatic logic [3:0] aluOp(input logic [2:0] f3, input logic f7, input logic isR);
        case (f3)
            3'b000:  aluOp = (isR && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  aluOp = ALU_SLL;
            3'b010:  aluOp = ALU_SLT;
            3'b011:  aluOp = ALU_SLTU;
            3'b100:  aluOp = ALU_XOR;
            3'b101:  aluOp = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  aluOp = ALU_OR;
            default: aluOp = ALU_AND;
        endcase
    endfunction

    logic       regWriteD, memWriteD, branchD, jumpD, aluSrcAD, aluSrcBD, pcTargetSrcD;
    logic [1:0] resultSrcD;
    logic [3:0] aluCtrlD;
    logic       legalD, unsignedOpD, loadD;

    always_comb begin
        regWriteD    = 1'b0;
        memWriteD    = 1'b0;
        branchD      = 1'b0;
        jumpD        = 1'b0;
        aluSrcAD     = 1'b0;
        aluSrcBD     = 1'b0;
        pcTargetSrcD = 1'b0;
        resultSrcD   = 2'd0;
        aluCtrlD     = ALU_ADD;
        ImmSrcD      = 3'd0;
        legalD       = 1'b1;
        unsignedOpD  = 1'b0;
        case (op)
            7'b0000011: begin legalD = (funct3 == 3'b010); regWriteD = 1'b1; resultSrcD = 2'd1; aluSrcBD = 1'b1; end
            7'b0100011: begin legalD = (funct3 == 3'b010); memWriteD = 1'b1; aluSrcBD = 1'b1; ImmSrcD = 3'd1; end
            7'b0110011: begin
                regWriteD   = 1'b1;
                aluCtrlD    = aluOp(funct3, funct7b5, 1'b1);
                unsignedOpD = (funct3 == 3'b011);
            end
            7'b0010011: begin
                regWriteD   = 1'b1;
                aluSrcBD    = 1'b1;
                aluCtrlD    = aluOp(funct3, funct7b5, 1'b0);
                unsignedOpD = (funct3 == 3'b011);
            end
            7'b1100011: begin
                legalD      = (funct3[2:1] != 2'b01);
                branchD     = 1'b1;
                aluCtrlD    = ALU_SUB;
                ImmSrcD     = 3'd2;
                unsignedOpD = (funct3[2:1] == 2'b11);
            end
            7'b1101111: begin regWriteD = 1'b1; jumpD = 1'b1; resultSrcD = 2'd2; ImmSrcD = 3'd3; end
            7'b1100111: begin
                legalD       = (funct3 == 3'b000);
                regWriteD    = 1'b1;
                jumpD        = 1'b1;
                resultSrcD   = 2'd2;
                aluSrcBD     = 1'b1;
                pcTargetSrcD = 1'b1;
            end
            7'b0110111: begin regWriteD = 1'b1; resultSrcD = 2'd3; aluSrcBD = 1'b1; ImmSrcD = 3'd4; end
            7'b0010111: begin regWriteD = 1'b1; aluSrcAD = 1'b1; aluSrcBD = 1'b1; ImmSrcD = 3'd4; end
            default:    legalD = 1'b0;
        endcase
`ifndef CONTROLLER_UNSIGNED_BRANCH_EN
        if (unsignedOpD) legalD = 1'b0;
`endif
    end

    assign IllegalD = InstrValidD & ~legalD;
    // Invalid or illegal instructions enter E as a zeroed bubble, same as a flush.
    assign loadD    = InstrValidD & legalD & ~FlushE;

    logic                 validE, regWriteE, memWriteE, branchE, jumpE;
    logic [2:0]           funct3E;
    logic                 validM, regWriteMq, memWriteMq;
    logic [1:0]           resultSrcM;
    logic                 validW, regWriteWq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validE       <= 1'b0;
            regWriteE    <= 1'b0;
            memWriteE    <= 1'b0;
            branchE      <= 1'b0;
            jumpE        <= 1'b0;
            funct3E      <= 3'd0;
            PCTargetSrcE <= 1'b0;
            ALUControlE  <= '0;
            ALUSrcAE     <= 1'b0;
            ALUSrcBE     <= 1'b0;
            ResultSrcE   <= 2'd0;
        end else if (!loadD) begin
            validE       <= 1'b0;
            regWriteE    <= 1'b0;
            memWriteE    <= 1'b0;
            branchE      <= 1'b0;
            jumpE        <= 1'b0;
            funct3E      <= 3'd0;
            PCTargetSrcE <= 1'b0;
            ALUControlE  <= '0;
            ALUSrcAE     <= 1'b0;
            ALUSrcBE     <= 1'b0;
            ResultSrcE   <= 2'd0;
        end else begin
            validE       <= 1'b1;
            regWriteE    <= regWriteD;
            memWriteE    <= memWriteD;
            branchE      <= branchD;
            jumpE        <= jumpD;
            funct3E      <= funct3;
            PCTargetSrcE <= pcTargetSrcD;
            ALUControlE  <= ALUCTRL_W'(aluCtrlD);
            ALUSrcAE     <= aluSrcAD;
            ALUSrcBE     <= aluSrcBD;
            ResultSrcE   <= resultSrcD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validM      <= 1'b0;
            regWriteMq  <= 1'b0;
            memWriteMq  <= 1'b0;
            resultSrcM  <= 2'd0;
            validW      <= 1'b0;
            regWriteWq  <= 1'b0;
            ResultSrcW  <= 2'd0;
            RetireCount <= '0;
        end else begin
            validM      <= validE;
            regWriteMq  <= regWriteE;
            memWriteMq  <= memWriteE;
            resultSrcM  <= ResultSrcE;
            validW      <= validM;
            regWriteWq  <= regWriteMq;
            ResultSrcW  <= resultSrcM;
            if (validW) RetireCount <= RetireCount + 1'b1;
        end
    end

    // Flags come from A-B; Carry set means no borrow, so unsigned less-than is ~C.
    logic condE;
    always_comb begin
        condE = 1'b0;
        case (funct3E)
            3'b000:  condE = ZeroE;
            3'b001:  condE = ~ZeroE;
            3'b100:  condE = NegativeE ^ OverflowE;
            3'b101:  condE = ~(NegativeE ^ OverflowE);
`ifdef CONTROLLER_UNSIGNED_BRANCH_EN
            3'b110:  condE = ~CarryE;
            3'b111:  condE = CarryE;
`endif
            default: condE = 1'b0;
        endcase
    end

`ifndef CONTROLLER_UNSIGNED_BRANCH_EN
    logic unusedCarry;
    assign unusedCarry = CarryE;
`endif

    assign PCSrcE    = validE & (jumpE | (branchE & condE));
    assign RegWriteM = regWriteMq & validM;
    assign MemWriteM = memWriteMq & validM;
    assign RegWriteW = regWriteWq & validW;
endmodule

// File: tb/tb_pipelined_controller_hz.sv
// Directed bench for pipelined_controller_hz: an expected-entry queue tracks each D instruction to E, M and W.
// A second instance with a 4-bit retire counter checks counter wrap.
module tb_pipelined_controller_hz;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
`ifdef CONTROLLER_UNSIGNED_BRANCH_EN
    localparam bit UNS_OK = 1'b1;
`else
    localparam bit UNS_OK = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memWrite;
        logic [1:0] resultSrc;
        logic       branch;
        logic       jump;
        logic       pcTgt;
        logic       aluSrcA;
        logic       aluSrcB;
        logic [3:0] aluCtrl;
        logic [2:0] f3;
    } ent_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, InstrValidD = 1'b0, FlushE = 1'b0;
    logic ZeroE = 1'b0, NegativeE = 1'b0, OverflowE = 1'b0, CarryE = 1'b0;
    logic [2:0] ImmSrcD;
    logic IllegalD, PCSrcE, PCTargetSrcE, ALUSrcAE, ALUSrcBE, RegWriteM, MemWriteM, RegWriteW;
    logic [3:0] ALUControlE;
    logic [1:0] ResultSrcE, ResultSrcW;
    logic [31:0] RetireCount;
    logic [2:0] immSrc4;
    logic ill4, pcSrc4, pcTgt4, srcA4, srcB4, regWriteM4, memWriteM4, regWriteW4;
    logic [3:0] aluCtrl4, retire4;
    logic [1:0] resE4, resW4;

    ent_t exp_q[$];
    int nCmp = 0, nErr = 0;
    logic [31:0] expCount = 0;

    always #5 clk = ~clk;

    pipelined_controller_hz #(.ALUCTRL_W(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .InstrValidD(InstrValidD), .FlushE(FlushE), .ZeroE(ZeroE), .NegativeE(NegativeE),
        .OverflowE(OverflowE), .CarryE(CarryE), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD),
        .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE), .ALUControlE(ALUControlE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .RetireCount(RetireCount)
    );

    pipelined_controller_hz #(.ALUCTRL_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .InstrValidD(InstrValidD), .FlushE(FlushE), .ZeroE(ZeroE), .NegativeE(NegativeE),
        .OverflowE(OverflowE), .CarryE(CarryE), .ImmSrcD(immSrc4), .IllegalD(ill4),
        .PCSrcE(pcSrc4), .PCTargetSrcE(pcTgt4), .ALUControlE(aluCtrl4),
        .ALUSrcAE(srcA4), .ALUSrcBE(srcB4), .ResultSrcE(resE4),
        .RegWriteM(regWriteM4), .MemWriteM(memWriteM4), .RegWriteW(regWriteW4),
        .ResultSrcW(resW4), .RetireCount(retire4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCmp++;
        assert (obs === expv) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] aluRef(input logic [2:0] f, input logic f7, input logic isR);
        case (f)
            3'd0:    return (isR && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic condRef(input logic [2:0] f, input logic [3:0] zncv);
        case (f)
            3'd0:    return zncv[3];
            3'd1:    return !zncv[3];
            3'd4:    return zncv[2] != zncv[1];
            3'd5:    return zncv[2] == zncv[1];
            3'd6:    return UNS_OK && !zncv[0];
            3'd7:    return UNS_OK && zncv[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic iv,
                         input logic fl, output logic legal, output logic ill,
                         output logic [2:0] imm, output ent_t e);
        ent_t d;
        d = '0;
        imm = 3'd0;
        legal = 1'b1;
        case (o)
            OP_LW:    begin legal = (f == 3'd2); d.regWrite = 1; d.resultSrc = 2'd1; d.aluSrcB = 1; end
            OP_SW:    begin legal = (f == 3'd2); d.memWrite = 1; d.aluSrcB = 1; imm = 3'd1; end
            OP_R:     begin d.regWrite = 1; d.aluCtrl = aluRef(f, f7, 1'b1); if (f == 3'd3) legal = UNS_OK; end
            OP_I:     begin
                d.regWrite = 1; d.aluSrcB = 1; d.aluCtrl = aluRef(f, f7, 1'b0);
                if (f == 3'd3) legal = UNS_OK;
            end
            OP_BR:    begin
                legal = (f != 3'd2) && (f != 3'd3) && (UNS_OK || f < 3'd6);
                d.branch = 1; d.aluCtrl = 4'd1; imm = 3'd2;
            end
            OP_JAL:   begin d.regWrite = 1; d.jump = 1; d.resultSrc = 2'd2; imm = 3'd3; end
            OP_JALR:  begin
                legal = (f == 3'd0); d.regWrite = 1; d.jump = 1; d.resultSrc = 2'd2;
                d.aluSrcB = 1; d.pcTgt = 1;
            end
            OP_LUI:   begin d.regWrite = 1; d.resultSrc = 2'd3; d.aluSrcB = 1; imm = 3'd4; end
            OP_AUIPC: begin d.regWrite = 1; d.aluSrcA = 1; d.aluSrcB = 1; imm = 3'd4; end
            default:  legal = 1'b0;
        endcase
        d.valid = 1'b1;
        d.f3 = f;
        ill = iv && !legal;
        e = (iv && legal && !fl) ? d : '0;
    endtask

    // One D cycle: drive, check D outputs, push the new entry, compare E/M/W against older entries.
    task automatic step(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic iv,
                        input logic fl, input logic [3:0] zncv);
        ent_t e, eE, eM, eW;
        logic legal, ill;
        logic [2:0] imm;
        @(negedge clk);
        op = o; funct3 = f; funct7b5 = f7; InstrValidD = iv; FlushE = fl;
        {ZeroE, NegativeE, OverflowE, CarryE} = zncv;
        #1;
        model(o, f, f7, iv, fl, legal, ill, imm, e);
        check("IllegalD", {31'd0, IllegalD}, {31'd0, ill});
        if (legal) check("ImmSrcD", {29'd0, ImmSrcD}, {29'd0, imm});
        exp_q.push_back(e);
        eE = exp_q[2];
        eM = exp_q[1];
        eW = exp_q[0];
        check("PCSrcE", {31'd0, PCSrcE},
              {31'd0, eE.valid & (eE.jump | (eE.branch & condRef(eE.f3, zncv)))});
        check("PCTargetSrcE", {31'd0, PCTargetSrcE}, {31'd0, eE.pcTgt});
        check("ALUControlE", {28'd0, ALUControlE}, {28'd0, eE.aluCtrl});
        check("ALUSrcE", {30'd0, ALUSrcAE, ALUSrcBE}, {30'd0, eE.aluSrcA, eE.aluSrcB});
        check("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, eE.resultSrc});
        check("WriteM", {30'd0, RegWriteM, MemWriteM},
              {30'd0, eM.valid & eM.regWrite, eM.valid & eM.memWrite});
        check("RegWriteW", {31'd0, RegWriteW}, {31'd0, eW.valid & eW.regWrite});
        check("ResultSrcW", {30'd0, ResultSrcW}, {30'd0, eW.resultSrc});
        check("RetireCount", RetireCount, expCount);
        check("RetireCount4", {28'd0, retire4}, {28'd0, expCount[3:0]});
        void'(exp_q.pop_front());
        if (eW.valid) expCount = expCount + 1;
    endtask

    task automatic bubble();
        step(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic doReset();
        @(negedge clk);
        op = '0; funct3 = '0; funct7b5 = 1'b0; InstrValidD = 1'b0; FlushE = 1'b0;
        {ZeroE, NegativeE, OverflowE, CarryE} = 4'b1111;
        reset = 1'b1;
        #1;
        check("rst_PCSrcE", {31'd0, PCSrcE}, 32'd0);
        check("rst_E", {23'd0, PCTargetSrcE, ALUControlE, ALUSrcAE, ALUSrcBE, ResultSrcE}, 32'd0);
        check("rst_MW", {27'd0, RegWriteM, MemWriteM, RegWriteW, ResultSrcW}, 32'd0);
        check("rst_RetireCount", RetireCount, 32'd0);
        check("rst_RetireCount4", {28'd0, retire4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        expCount = 0;
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        doReset();
        step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_I, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_BR, 3'd5, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(OP_BR, 3'd6, 1'b0, 1'b1, 1'b0, 4'b0110);
        step(OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, 4'b0001);
        step(OP_BR, 3'd4, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(OP_SW, 3'd2, 1'b0, 1'b1, 1'b1, 4'b0100);
        step(OP_LW, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_SW, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_LUI, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_JAL, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_AUIPC, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_R, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_BR, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_R, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        step(OP_I, 3'd5, 1'b1, 1'b1, 1'b0, 4'd0);
        step(OP_I, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_BR, 3'd7, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_LW, 3'd0, 1'b0, 1'b1, 1'b0, 4'b0001);
        doReset();
        step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (4) bubble();
        check("retire3", RetireCount, 32'd3);
        for (int i = 0; i < 40; i++)
            step(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
        repeat (4) bubble();
        doReset();
        repeat (17) step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (4) bubble();
        check("wrap4", {28'd0, retire4}, 32'd1);
        check("wrap32", RetireCount, 32'd17);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipelined_controller_hz.md
# pipelined_controller_hz

Pipelined RV32I control unit with hazard hooks: decodes the instruction in DECODE and carries control bits through the D→E→M→W control pipeline registers. Those registers support flush, and a per-stage valid bit qualifies every side effect. Beyond BEQ/BLT, it resolves the full branch set from four ALU flags and counts retired instructions. It sits beside the datapath and hazard unit in the five-stage core.

## Interface
- `ALUCTRL_W`, 4: ALUControl width (≥4).
- `CNT_W`, 32: retire counter width.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all registers.
- `op` input 7: opcode, D.
- `funct3` input 3: D.
- `funct7b5` input 1: D.
- `InstrValidD` input 1: D holds a real instruction (0 after FlushD/reset).
- `FlushE` input 1: bubble into E next cycle (from hazard unit).
- `ZeroE`, `NegativeE`, `OverflowE`, `CarryE` input 1 each: ALU flags of A−B; Carry=1 means no borrow.
- `ImmSrcD` output 3: 0=I, 1=S, 2=B, 3=J, 4=U.
- `IllegalD` output 1: valid D instruction with undecodable opcode/funct.
- `PCSrcE` output 1: take branch/jump.
- `PCTargetSrcE` output 1: 1=ALU result (JALR), 0=PC+imm.
- `ALUControlE` output `ALUCTRL_W`: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
- `ALUSrcAE` output 1: 1=PC (AUIPC).
- `ALUSrcBE` output 1: 1=immediate.
- `ResultSrcE` output 2: to hazard unit.
- `RegWriteM` output 1.
- `MemWriteM` output 1.
- `RegWriteW` output 1.
- `ResultSrcW` output 2: 0 ALU, 1 mem, 2 PC+4, 3 ImmExt (LUI).
- `RetireCount` output `CNT_W`: instructions retired since reset.

## Operation
- Decode (combinational, D): lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111. Anything else, or an unsupported funct3, is illegal: `IllegalD`=InstrValidD, and the instruction is decoded as a bubble (no RegWrite, MemWrite, Jump or Branch).
- Branch and ALU: branches use sub. R-type sub only when funct7b5=1; I-type srai when funct7b5=1, and addi ignores funct7b5.
- Stage valid: validE ← InstrValidD & ~IllegalD & ~FlushE. validM ← validE. validW ← validM.
- D→E register: on FlushE, all fields load 0 (bubble). E→M and M→W registers load every cycle.
- Qualification: RegWriteM, MemWriteM, RegWriteW and PCSrcE are ANDed with their stage valid.
- PCSrcE = validE & (JumpE | (BranchE & cond)), with cond by funct3E:
  - BEQ: Z.
  - BNE: ~Z.
  - BLT: N^V.
  - BGE: ~(N^V).
  - BLTU: ~C.
  - BGEU: C.
- Retire counter: RetireCount increments when validW=1 and wraps modulo 2^CNT_W.

## Timing
- Reset: all pipeline registers, valid bits and RetireCount are 0. Consequently every E/M/W output is 0 and PCSrcE=0. Reset asserted mid-operation squashes in-flight instructions immediately (asynchronous).
- Latency: D→E is 1 cycle, E→M 1, M→W 1. A decoded instruction retires, and is counted, in the cycle after it reaches W; counter latency is 4 cycles after D.
- PCSrcE is combinational in E, valid the same cycle as the flags.
- FlushE and a valid D instruction in the same cycle: the flush wins, the instruction is dropped and not counted.
- Priority: reset > FlushE > load.

## Configuration
- `CONTROLLER_UNSIGNED_BRANCH_EN` defined: BLTU, BGEU, SLTU and SLTIU decode normally.
- Undefined: those four are illegal (IllegalD=1, bubble), and CarryE is ignored.

## Test plan
- Reset: assert reset mid-stream → all outputs 0 and RetireCount=0 in the same cycle. Deassert, then issue 3 addi → RetireCount=3 four cycles after the last one leaves D.
- Branch conditions: BNE with Z=0 → PCSrcE=1. BGE with N=1, V=1 → PCSrcE=1. BLTU with C=1 → PCSrcE=0 (macro on).
- Flush: sw in D with FlushE=1 → MemWriteM=0 two cycles later and RetireCount unchanged.
- Jumps: jalr → PCSrcE=1, PCTargetSrcE=1, ResultSrcW=2, RegWriteW=1. lui → ImmSrcD=4, ResultSrcW=3.
- Illegal opcode 0000000 with InstrValidD=1 → IllegalD=1, no writes, not counted. With the macro off, sltu → IllegalD=1.
- Counter wrap: CNT_W=4, 17 retirements → RetireCount=1.
